// File: rtl/mod_expo_engine.sv
// mod_expo_engine: Montgomery-domain modular exponentiation controller, z = x^e mod m
// Ports:
//   clk, reset_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready     operand handshake carrying base x (K bits) and exponent e (EW bits)
//   abort                 synchronous cancel, returns to IDLE from any busy state
//   out_valid/out_ready   result handshake carrying z (K bits)
//   busy                  high in every state except IDLE
//   mm_start/mm_a/mm_b    request to the external multiplier MM(a,b) = a*b*2^-K mod m
//   mm_done/mm_p          multiplier completion pulse and product
// Build option: define LADDER_EN for the constant-time Montgomery ladder;
//   otherwise left-to-right square-and-multiply with leading-zero skip.
module mod_expo_engine #(
   parameter int K = 192,
   parameter int EW = 192,
   parameter int LOGE = 8,
   parameter logic [K-1:0] RMOD = 192'h000000000000000000000000000000010000000000000001,
   parameter logic [K-1:0] R2MOD = 192'h000000000000000100000000000000020000000000000001
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [K-1:0]  x,
   input  logic [EW-1:0] e,
   input  logic          abort,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [K-1:0]  z,
   output logic          busy,
   output logic          mm_start,
   output logic [K-1:0]  mm_a,
   output logic [K-1:0]  mm_b,
   input  logic          mm_done,
   input  logic [K-1:0]  mm_p
);
   typedef enum logic [3:0] {IDLE, TOX, SKIP, SQ, MUL, LADA, LADB, FROM, OUT} state_t;
   state_t state, state_nx;
   logic [K-1:0] x_reg, r0, z_reg;
`ifdef LADDER_EN
   logic [K-1:0] r1;
`else
   logic [K-1:0] xt;
`endif
   logic [EW-1:0] e_sh;
   logic [LOGE-1:0] cnt;
   logic started, is_mul, done, last, shift;
   assign in_ready = state == IDLE;
   assign busy = state != IDLE;
   assign out_valid = state == OUT;
   assign z = z_reg;
   always_comb begin
      is_mul = state inside {TOX, SQ, MUL, LADA, LADB, FROM};
      // started marks that this multiply has been issued; a same-state repeat (SQ->SQ) clears it
      mm_start = is_mul && !started && !abort;
      done = is_mul && started && mm_done && !abort;
      last = cnt == LOGE'(1);
      shift = 1'b0;
      mm_a = '0;
      mm_b = '0;
      state_nx = state;
      case (state)
         IDLE: state_nx = in_valid ? TOX : IDLE;
         TOX: begin
            mm_a = x_reg;
            mm_b = R2MOD;
`ifdef LADDER_EN
            if (done) state_nx = LADA;
`else
            if (done) state_nx = SKIP;
`endif
         end
`ifdef LADDER_EN
         LADA: begin
            mm_a = r0;
            mm_b = r1;
            if (done) state_nx = LADB;
         end
         LADB: begin
            mm_a = e_sh[EW-1] ? r1 : r0;
            mm_b = e_sh[EW-1] ? r1 : r0;
            shift = done;
            if (done) state_nx = last ? FROM : LADA;
         end
`else
         SKIP: begin
            shift = cnt != '0 && !e_sh[EW-1];
            state_nx = cnt == '0 ? FROM : e_sh[EW-1] ? SQ : SKIP;
         end
         SQ: begin
            mm_a = r0;
            mm_b = r0;
            shift = done && !e_sh[EW-1];
            if (done) state_nx = e_sh[EW-1] ? MUL : last ? FROM : SQ;
         end
         MUL: begin
            mm_a = r0;
            mm_b = xt;
            shift = done;
            if (done) state_nx = last ? FROM : SQ;
         end
`endif
         FROM: begin
            mm_a = r0;
            mm_b = K'(1);
            if (done) state_nx = OUT;
         end
         OUT: state_nx = out_ready ? IDLE : OUT;
         default: state_nx = IDLE;
      endcase
      if (abort && state != IDLE) state_nx = IDLE;
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else state <= state_nx;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         started <= 1'b0;
         x_reg <= '0;
         e_sh <= '0;
         cnt <= '0;
         r0 <= '0;
         z_reg <= '0;
`ifdef LADDER_EN
         r1 <= '0;
`else
         xt <= '0;
`endif
      end else begin
         started <= (done || abort) ? 1'b0 : started || mm_start;
         if (state == IDLE && in_valid) begin
            x_reg <= x;
            e_sh <= e;
            cnt <= LOGE'(EW);
            r0 <= RMOD;
         end
         if (shift) begin
            e_sh <= e_sh << 1;
            cnt <= cnt - 1'b1;
         end
         if (done)
            case (state)
`ifdef LADDER_EN
               TOX: r1 <= mm_p;
               LADA: if (e_sh[EW-1]) r0 <= mm_p; else r1 <= mm_p;
               LADB: if (e_sh[EW-1]) r1 <= mm_p; else r0 <= mm_p;
`else
               TOX: xt <= mm_p;
               SQ, MUL: r0 <= mm_p;
`endif
               FROM: z_reg <= mm_p;
               default: ;
            endcase
      end
endmodule
